// File: rtl/monitor_sys.sv
// monitor_sys: SPI-slave control block between an external monitor MCU and the emulator core.
//
// The MCU sends byte commands over SPI. This block answers with a NUL-terminated config string
// or latched joystick state. It also holds core_config, the overlay enable/colour and the ROM
// loading flag, and forwards streamed ROM bytes to the core.
//
// Ports:
//   clk, resetn          system clock, asynchronous active-low reset
//   overlay              overlay enable
//   overlay_x/overlay_y  current pixel position (reserved, unused)
//   overlay_color        RGB555 overlay pixel, zero while overlay is off
//   joy1, joy2           player button inputs, latched by the joystick command
//   rom_loading          high while the core should accept ROM data
//   rom_do/rom_do_valid  ROM data byte and its one-clk strobe
//   core_config          32-bit core option word
//   sspi_cs/clk/mosi     SPI slave inputs (cs active low)
//   sspi_miso            SPI slave output, 0 while cs is high
module monitor_sys #(
  parameter int unsigned FREQ    = 21_477_000,
  parameter int unsigned CORE_ID = 1
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        overlay,
  input  logic [7:0]  overlay_x,
  input  logic [7:0]  overlay_y,
  output logic [14:0] overlay_color,
  input  logic [11:0] joy1,
  input  logic [11:0] joy2,
  output logic        rom_loading,
  output logic [7:0]  rom_do,
  output logic        rom_do_valid,
  output logic [31:0] core_config,
  input  logic        sspi_cs,
  input  logic        sspi_clk,
  input  logic        sspi_mosi,
  output logic        sspi_miso
);

  typedef enum logic [1:0] {StIdle, StArgs, StRomData} state_e;
  typedef enum logic [1:0] {SrcNone, SrcCfg, SrcJoy} src_e;

  localparam logic [7:0] IdChar = (CORE_ID < 10) ? 8'(CORE_ID + 32'h30) : 8'(CORE_ID + 32'h37);

  logic unused_inputs;
  assign unused_inputs = ^{overlay_x, overlay_y, 32'(FREQ)};

  // ---------------------------------------------------------------------------------------------
  // SPI clock domain
  // ---------------------------------------------------------------------------------------------
  // Bit counter, shifter and start-of-frame flag are cleared whenever cs is high (or in reset).
  logic       spi_clr;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic       first_q;

  assign spi_clr = sspi_cs | ~resetn;

  always_ff @(posedge sspi_clk or posedge spi_clr) begin
    if (spi_clr) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      first_q   <= 1'b1;
    end else begin
      bit_cnt_q <= bit_cnt_q + 3'd1;
      shift_q   <= {shift_q[5:0], sspi_mosi};
      if (bit_cnt_q == 3'd7) first_q <= 1'b0;
    end
  end

  // Completed byte plus its "first byte of frame" tag. Held stable until the next byte, which
  // is at least 8 sclk periods later, so the clk side may sample it after the toggle syncs.
  // Held in reset so a byte finishing during reset never raises a toggle.
  logic       byte_tgl_q;
  logic [7:0] rx_byte_q;
  logic       rx_first_q;

  always_ff @(posedge sspi_clk or negedge resetn) begin
    if (!resetn) begin
      byte_tgl_q <= 1'b0;
      rx_byte_q  <= '0;
      rx_first_q <= 1'b0;
    end else if (!sspi_cs && bit_cnt_q == 3'd7) begin
      byte_tgl_q <= ~byte_tgl_q;
      rx_byte_q  <= {shift_q, sspi_mosi};
      rx_first_q <= first_q;
    end
  end

  // tx_q is a clk-domain register that is stable well before cs falls.
  logic [7:0] tx_q, tx_d;
  assign sspi_miso = ~sspi_cs & tx_q[~bit_cnt_q];

  // ---------------------------------------------------------------------------------------------
  // Byte hand-off into clk: 2-FF synchronizer plus one stage for edge detection
  // ---------------------------------------------------------------------------------------------
  logic [2:0] tgl_sync_q;
  logic       byte_evt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) tgl_sync_q <= '0;
    else         tgl_sync_q <= {tgl_sync_q[1:0], byte_tgl_q};
  end

  assign byte_evt = tgl_sync_q[2] ^ tgl_sync_q[1];

  // ---------------------------------------------------------------------------------------------
  // Command FSM
  // ---------------------------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [1:0] arg_cnt_q, arg_cnt_d;

  // Index of the final argument byte for each command that takes arguments.
  function automatic logic [1:0] last_arg(input logic [7:0] cmd);
    case (cmd)
      8'd2:    last_arg = 2'd3;
      8'd4:    last_arg = 2'd1;
      8'd7:    last_arg = 2'd2;
      default: last_arg = 2'd0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cmd_q     <= '0;
      arg_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      arg_cnt_q <= arg_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    arg_cnt_d = arg_cnt_q;
    if (byte_evt) begin
      if (rx_first_q) begin
        // A new frame always restarts decoding, which is what discards aborted frames.
        cmd_d     = rx_byte_q;
        arg_cnt_d = '0;
        state_d   = (rx_byte_q inside {[8'd1:8'd7]}) ? StArgs : StIdle;
      end else if (state_q == StArgs) begin
        if (arg_cnt_q == last_arg(cmd_q)) begin
          state_d = (cmd_q == 8'd7) ? StRomData : StIdle;
        end else begin
          arg_cnt_d = arg_cnt_q + 2'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------------------------
  logic        arg_evt, arg_last, data_evt, read_evt;
  logic [23:0] cfg_shift_q, cfg_shift_d;
  logic [31:0] core_config_q, core_config_d;
  logic        overlay_q, overlay_d;
  logic [6:0]  color_hi_q, color_hi_d;
  logic [14:0] color_q, color_d;
  logic [14:0] overlay_color_q, overlay_color_d;
  logic        rom_loading_q, rom_loading_d;
  logic [23:0] len_q, len_d;
  logic [7:0]  rom_do_q, rom_do_d;
  logic        rom_do_valid_q, rom_do_valid_d;
  src_e        src_q, src_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [11:0] joy1_lat_q, joy1_lat_d;
  logic [11:0] joy2_lat_q, joy2_lat_d;

  assign arg_evt  = byte_evt && !rx_first_q && (state_q == StArgs);
  assign arg_last = arg_evt && (arg_cnt_q == last_arg(cmd_q));
  assign data_evt = byte_evt && !rx_first_q && (state_q == StRomData);
  assign read_evt = byte_evt && rx_first_q && (rx_byte_q == 8'h00);

  function automatic logic [7:0] cfg_char(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd2:  cfg_char = 8'h53; // S
      4'd1:        cfg_char = 8'h59; // Y
      4'd3, 4'd8:  cfg_char = 8'h20; // space
      4'd4:        cfg_char = 8'h43; // C
      4'd5:        cfg_char = 8'h4F; // O
      4'd6:        cfg_char = 8'h52; // R
      4'd7:        cfg_char = 8'h45; // E
      4'd9:        cfg_char = IdChar;
      default:     cfg_char = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] joy_byte(input logic [3:0] idx, input logic [11:0] j1,
                                          input logic [11:0] j2);
    case (idx)
      4'd0:    joy_byte = j1[7:0];
      4'd1:    joy_byte = {4'b0, j1[11:8]};
      4'd2:    joy_byte = j2[7:0];
      4'd3:    joy_byte = {4'b0, j2[11:8]};
      default: joy_byte = 8'h00;
    endcase
  endfunction

  always_comb begin
    cfg_shift_d    = cfg_shift_q;
    core_config_d  = core_config_q;
    overlay_d      = overlay_q;
    color_hi_d     = color_hi_q;
    color_d        = color_q;
    rom_loading_d  = rom_loading_q;
    len_d          = len_q;
    rom_do_d       = rom_do_q;
    rom_do_valid_d = 1'b0;
    src_d          = src_q;
    ptr_d          = ptr_q;
    joy1_lat_d     = joy1_lat_q;
    joy2_lat_d     = joy2_lat_q;

    // Pointer sticks on a NUL so repeated reads keep returning 0x00.
    if (read_evt && tx_q != 8'h00) ptr_d = ptr_q + 4'd1;

    if (arg_evt) begin
      case (cmd_q)
        8'd1: begin
          src_d = SrcCfg;
          ptr_d = '0;
        end
        8'd2: begin
          cfg_shift_d = {cfg_shift_q[15:0], rx_byte_q};
          if (arg_last) core_config_d = {cfg_shift_q, rx_byte_q};
        end
        8'd3: overlay_d = rx_byte_q[0];
        8'd4: begin
          if (arg_last) color_d = {color_hi_q, rx_byte_q};
          else          color_hi_d = rx_byte_q[6:0];
        end
        8'd5: begin
          src_d      = SrcJoy;
          ptr_d      = '0;
          joy1_lat_d = joy1;
          joy2_lat_d = joy2;
        end
        8'd6: rom_loading_d = rx_byte_q[0];
        8'd7: len_d = {len_q[15:0], rx_byte_q};
        default: ;
      endcase
    end

    if (data_evt && len_q != '0) begin
      rom_do_d       = rx_byte_q;
      rom_do_valid_d = 1'b1;
      len_d          = len_q - 24'd1;
    end

    overlay_color_d = overlay_q ? color_q : '0;

    case (src_q)
      SrcCfg:  tx_d = cfg_char(ptr_q);
      SrcJoy:  tx_d = joy_byte(ptr_q, joy1_lat_q, joy2_lat_q);
      default: tx_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cfg_shift_q     <= '0;
      core_config_q   <= '0;
      overlay_q       <= 1'b0;
      color_hi_q      <= '0;
      color_q         <= '0;
      overlay_color_q <= '0;
      rom_loading_q   <= 1'b0;
      len_q           <= '0;
      rom_do_q        <= '0;
      rom_do_valid_q  <= 1'b0;
      src_q           <= SrcNone;
      ptr_q           <= '0;
      joy1_lat_q      <= '0;
      joy2_lat_q      <= '0;
      tx_q            <= '0;
    end else begin
      cfg_shift_q     <= cfg_shift_d;
      core_config_q   <= core_config_d;
      overlay_q       <= overlay_d;
      color_hi_q      <= color_hi_d;
      color_q         <= color_d;
      overlay_color_q <= overlay_color_d;
      rom_loading_q   <= rom_loading_d;
      len_q           <= len_d;
      rom_do_q        <= rom_do_d;
      rom_do_valid_q  <= rom_do_valid_d;
      src_q           <= src_d;
      ptr_q           <= ptr_d;
      joy1_lat_q      <= joy1_lat_d;
      joy2_lat_q      <= joy2_lat_d;
      tx_q            <= tx_d;
    end
  end

  assign overlay       = overlay_q;
  assign overlay_color = overlay_color_q;
  assign rom_loading   = rom_loading_q;
  assign rom_do        = rom_do_q;
  assign rom_do_valid  = rom_do_valid_q;
  assign core_config   = core_config_q;

endmodule

// File: tb/tb_monitor_sys.sv
// Self-checking bench for monitor_sys: an SPI master drives command frames, a reference model
// predicts responses, and monitor processes compare MISO read bytes and ROM strobes.
module tb_monitor_sys;

  localparam int TbCoreId = 1;
  localparam int Sh       = 100;  // half sclk period; clk period is 46

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        overlay;
  logic [7:0]  overlay_x = 8'd0;
  logic [7:0]  overlay_y = 8'd0;
  logic [14:0] overlay_color;
  logic [11:0] joy1 = '0;
  logic [11:0] joy2 = '0;
  logic        rom_loading;
  logic [7:0]  rom_do;
  logic        rom_do_valid;
  logic [31:0] core_config;
  logic        sspi_cs = 1'b1;
  logic        sspi_clk = 1'b0;
  logic        sspi_mosi = 1'b0;
  logic        sspi_miso;

  always #23 clk = ~clk;

  monitor_sys #(.FREQ(21_477_000), .CORE_ID(TbCoreId)) dut (
    .clk(clk), .resetn(resetn), .overlay(overlay), .overlay_x(overlay_x),
    .overlay_y(overlay_y), .overlay_color(overlay_color), .joy1(joy1), .joy2(joy2),
    .rom_loading(rom_loading), .rom_do(rom_do), .rom_do_valid(rom_do_valid),
    .core_config(core_config), .sspi_cs(sspi_cs), .sspi_clk(sspi_clk),
    .sspi_mosi(sspi_mosi), .sspi_miso(sspi_miso)
  );

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard queues
  logic [7:0] exp_rx_q[$];
  logic [7:0] act_rx_q[$];
  logic [7:0] exp_rom_q[$];
  int         rom_exp_cnt = 0;
  int         rom_seen = 0;

  // Reference model state
  logic [31:0] m_cfg = '0;
  logic        m_overlay = 1'b0;
  logic [14:0] m_color = '0;
  logic        m_rom_loading = 1'b0;
  logic [7:0]  m_resp[16];
  int          m_ptr = 0;

  logic [7:0]  fb[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cfg = '0; m_overlay = 1'b0; m_color = '0; m_rom_loading = 1'b0; m_ptr = 0;
    for (int i = 0; i < 16; i++) m_resp[i] = 8'h00;
  endtask

  task automatic check_regs(input string tag);
    @(negedge clk);
    check({tag, ".core_config"}, core_config, m_cfg);
    check({tag, ".overlay"}, {31'b0, overlay}, {31'b0, m_overlay});
    check({tag, ".overlay_color"}, {17'b0, overlay_color}, {17'b0, (m_overlay ? m_color : 15'h0)});
    check({tag, ".rom_loading"}, {31'b0, rom_loading}, {31'b0, m_rom_loading});
  endtask

  // One SPI byte: MOSI set while sclk low, MISO sampled just before the rising edge.
  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      sspi_mosi = b[i];
      #Sh;
      r[i] = sspi_miso;
      sspi_clk = 1'b1;
      #Sh;
      sspi_clk = 1'b0;
    end
  endtask

  task automatic frame(input int n, output logic [7:0] first_rx);
    logic [7:0] r;
    first_rx = '0;
    sspi_cs = 1'b0;
    #Sh;
    for (int i = 0; i < n; i++) begin
      spi_byte(fb[i], r);
      if (i == 0) first_rx = r;
    end
    #Sh;
    sspi_cs = 1'b1;
  endtask

  task automatic gap();
    #1000;
  endtask

  task automatic do_read();
    logic [7:0] e, r;
    e = (m_ptr < 16) ? m_resp[m_ptr] : 8'h00;
    exp_rx_q.push_back(e);
    if (e != 8'h00) m_ptr++;
    fb[0] = 8'h00;
    frame(1, r);
    act_rx_q.push_back(r);
    gap();
  endtask

  task automatic cmd_sel_cfg();
    logic [7:0] r;
    string s, hexs;
    s = "SYS CORE ";
    hexs = "0123456789ABCDEF";
    for (int i = 0; i < 16; i++) m_resp[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) m_resp[i] = s[i];
    m_resp[s.len()] = hexs[TbCoreId];
    m_ptr = 0;
    fb[0] = 8'd1; fb[1] = 8'($urandom_range(0, 255));
    frame(2, r);
    gap();
  endtask

  task automatic cmd_joy();
    logic [7:0] r;
    for (int i = 0; i < 16; i++) m_resp[i] = 8'h00;
    m_resp[0] = joy1[7:0]; m_resp[1] = {4'h0, joy1[11:8]};
    m_resp[2] = joy2[7:0]; m_resp[3] = {4'h0, joy2[11:8]};
    m_ptr = 0;
    fb[0] = 8'd5; fb[1] = 8'($urandom_range(0, 255));
    frame(2, r);
    gap();
  endtask

  task automatic cmd_config(input logic [31:0] v, input int nargs);
    logic [7:0] r;
    fb[0] = 8'd2; fb[1] = v[31:24]; fb[2] = v[23:16]; fb[3] = v[15:8]; fb[4] = v[7:0];
    if (nargs == 4) m_cfg = v;
    frame(1 + nargs, r);
  endtask

  task automatic cmd_overlay(input logic b);
    logic [7:0] r;
    fb[0] = 8'd3; fb[1] = {7'($urandom_range(0, 127)), b};
    m_overlay = b;
    frame(2, r);
    gap();
  endtask

  task automatic cmd_color(input logic [15:0] c);
    logic [7:0] r;
    fb[0] = 8'd4; fb[1] = c[15:8]; fb[2] = c[7:0];
    m_color = c[14:0];
    frame(3, r);
    gap();
  endtask

  task automatic cmd_romload(input logic b);
    logic [7:0] r;
    fb[0] = 8'd6; fb[1] = {7'($urandom_range(0, 127)), b};
    m_rom_loading = b;
    frame(2, r);
    gap();
  endtask

  task automatic cmd_rom(input int len, input int extra, input logic fixed);
    logic [7:0] r;
    fb[0] = 8'd7; fb[1] = 8'(len >> 16); fb[2] = 8'(len >> 8); fb[3] = 8'(len);
    for (int i = 0; i < len + extra; i++) begin
      fb[4 + i] = fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom_range(0, 255));
      if (i < len) begin
        exp_rom_q.push_back(fb[4 + i]);
        rom_exp_cnt++;
      end
    end
    frame(4 + len + extra, r);
    gap();
  endtask

  // Read-byte monitor
  initial begin
    logic [7:0] a, e;
    forever begin
      @(negedge clk);
      if (exp_rx_q.size() > 0 && act_rx_q.size() > 0) begin
        a = act_rx_q.pop_front();
        e = exp_rx_q.pop_front();
        check("miso_read", {24'b0, a}, {24'b0, e});
      end
    end
  end

  // ROM strobe monitor
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rom_do_valid) begin
        rom_seen++;
        if (exp_rom_q.size() > 0) begin
          e = exp_rom_q.pop_front();
          check("rom_do", {24'b0, rom_do}, {24'b0, e});
        end
      end
    end
  end

  initial begin
    logic [7:0] r;
    logic [31:0] v;
    model_reset();
    #100;
    check_regs("reset");
    check("reset.rom_do", {23'b0, rom_do_valid, rom_do}, 32'h0);
    resetn = 1'b1;
    gap();

    // No source selected: reads give 0x00
    do_read();
    do_read();

    // Config string, then trailing NULs
    cmd_sel_cfg();
    for (int i = 0; i < 13; i++) do_read();

    // core_config write, checked within 300 of cs rising
    cmd_config(32'hA5A5A5A5, 4);
    #277;
    check_regs("cfg_a5");
    gap();
    cmd_config(32'h1234_5678, 2);  // aborted after two argument bytes
    gap();
    check_regs("cfg_abort");
    for (int k = 0; k < 3; k++) begin
      v = $urandom;
      cmd_config(v, 4);
      gap();
      check_regs("cfg_rand");
    end

    // Overlay and colour
    cmd_overlay(1'b1);
    cmd_color(16'h7FFF);
    check_regs("ovl_on");
    cmd_overlay(1'b0);
    check_regs("ovl_off");
    for (int k = 0; k < 4; k++) begin
      cmd_color(16'($urandom));
      cmd_overlay(1'($urandom));
      check_regs("ovl_rand");
    end

    // Joystick latch
    joy1 = 12'hA5C;
    joy2 = 12'h3F0;
    cmd_joy();
    joy1 = 12'h000;
    joy2 = 12'hFFF;
    for (int i = 0; i < 5; i++) do_read();
    for (int k = 0; k < 2; k++) begin
      joy1 = 12'($urandom);
      joy2 = 12'($urandom);
      cmd_joy();
      joy1 = 12'($urandom);
      for (int i = 0; i < 6; i++) do_read();
    end

    // ROM streaming
    cmd_romload(1'b1);
    check_regs("romload_on");
    cmd_rom(3, 1, 1'b1);
    cmd_rom(0, 2, 1'b0);
    for (int k = 0; k < 3; k++) cmd_rom($urandom_range(1, 6), $urandom_range(0, 2), 1'b0);
    cmd_romload(1'b0);
    check_regs("romload_off");
    cmd_rom(2, 1, 1'b0);
    check("rom_count_pre_reset", rom_seen, rom_exp_cnt);

    // Reset in the middle of a ROM frame
    sspi_cs = 1'b0;
    #Sh;
    spi_byte(8'h07, r);
    spi_byte(8'h00, r);
    spi_byte(8'h00, r);
    spi_byte(8'h05, r);
    exp_rom_q.push_back(8'hAA); rom_exp_cnt++;
    exp_rom_q.push_back(8'hBB); rom_exp_cnt++;
    spi_byte(8'hAA, r);
    spi_byte(8'hBB, r);
    #1000;
    resetn = 1'b0;
    model_reset();
    #100;
    check_regs("mid_reset");
    check("mid_reset.rom_do", {23'b0, rom_do_valid, rom_do}, 32'h0);
    spi_byte(8'hCC, r);
    spi_byte(8'hDD, r);
    #Sh;
    sspi_cs = 1'b1;
    #200;
    resetn = 1'b1;
    gap();
    check("rom_count_post_reset", rom_seen, rom_exp_cnt);

    // Decoding resumes normally
    cmd_overlay(1'b1);
    cmd_color(16'h1234);
    check_regs("post_reset");
    do_read();
    cmd_sel_cfg();
    do_read();
    do_read();

    for (int i = 0; i < 1000 && exp_rx_q.size() != 0; i++) @(negedge clk);
    check("rx_queue_drained", exp_rx_q.size(), 0);
    check("rom_queue_drained", exp_rom_q.size(), 0);
    check("rom_count_final", rom_seen, rom_exp_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
